board_ram_arbiter: RTL and testbench
====================================

Name: board_ram_arbiter

Overview:
- Shares the single-port 40-bit x 32-row board RAM between three requesters:
  - preset loader (write-only);
  - life-rule engine (read/write);
  - VGA display scanner (read-only).
- Grants one RAM access per cycle using fixed priority with burst ownership, plus a starvation guard so the display always makes progress.
- Sits between the top-level control FSM blocks and the board RAM instance. It owns the RAM address, data, wren and q nets exclusively.

Parameters:
WIDTH, 40, row width in cells (RAM data width)
AW, 5, RAM address width
ROWS, 30, number of valid board rows; addresses >= ROWS are out of range
MAX_WAIT, 16, cycles the display may wait with req high before it forces ownership

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_p  in  1  preset loader request (write)
addr_p  in  AW  preset row address
wdata_p  in  WIDTH  preset row data
gnt_p  out  1  preset access performed this cycle
req_e  in  1  engine request
we_e  in  1  engine write enable (0 = read)
addr_e  in  AW  engine row address
wdata_e  in  WIDTH  engine write data
gnt_e  out  1  engine access performed this cycle
rvalid_e  out  1  engine read data valid on rdata
req_d  in  1  display read request
addr_d  in  AW  display row address
gnt_d  out  1  display access performed this cycle
rvalid_d  out  1  display read data valid on rdata
rdata  out  WIDTH  read data (shared; qualified by rvalid_e/rvalid_d)
err_oob  out  1  sticky out-of-range access flag
ram_addr  out  AW  RAM address
ram_data  out  WIDTH  RAM write data
ram_wren  out  1  RAM write enable
ram_q  in  WIDTH  RAM read data, 1-cycle synchronous latency

Behaviour:
- State register `owner` ∈ {IDLE, OWN_P, OWN_E, OWN_D}, plus a display wait counter (clog2(MAX_WAIT+1) bits).
- Async reset (reset_n=0):
  - owner=IDLE, wait counter=0, err_oob=0, rvalid_e/rvalid_d=0.
  - All gnt outputs 0 immediately. ram_wren=0 immediately; any write in that cycle is aborted.
  - ram_addr and ram_data = 0.
- Grant is combinational from the registered owner: gnt_X = (owner==OWN_X) & req_X. At most one gnt is high in any cycle.
- RAM drive: ram_addr and ram_data come from the granted requester. When nothing is granted, ram_addr=0, ram_data=0 and ram_wren=0.
- ram_wren is high only when all hold:
  - (gnt_p or (gnt_e & we_e));
  - address < ROWS.
- Read latency: rvalid_e / rvalid_d are registered, high exactly 1 cycle after a granted engine read / display read.
  - rdata = ram_q in that cycle.
  - If the read address was out of range, rdata = 0 instead (out-of-range flag registered alongside rvalid).
- Out of range (addr >= ROWS): the write is suppressed, but gnt is still given. err_oob is set at the next edge and stays set until reset.
- Ownership update at each rising edge:
  - Stays with the current owner while that owner's req stays high (burst), unless the starvation guard fires.
  - Otherwise, on owner req low or owner IDLE, the next owner is the highest-priority active request: P > E > D. With no requests, next owner is IDLE.
  - Arbitration latency: a req asserted while its requester is not the owner is granted no earlier than the next cycle.
- Starvation guard:
  - The wait counter increments each cycle req_d=1 and gnt_d=0, saturating at MAX_WAIT.
  - The counter clears when gnt_d=1 or req_d=0.
  - When the counter == MAX_WAIT at an edge, the next owner is OWN_D regardless of the current owner.
  - The display is then released after one access: the following edge re-arbitrates with P > E > D, and the display is not eligible to retain ownership.
  - The displaced requester keeps req high and resumes when re-granted. No access is lost, because gnt was low.
- Simultaneous events:
  - Requests arriving together from IDLE follow priority.
  - Guard firing and the owner dropping req in the same cycle: the guard wins.
  - Requester dropping req in the cycle it is granted: gnt goes low combinationally; no access occurs.
- Requesters must hold addr, wdata and we stable while req is high and gnt is low.
- Reset mid-burst: ownership is lost, and requesters re-request after reset is released.

Test Plan:
1. Reset, then req_p=1 with addr_p 0..29 and wdata_p=row index -> gnt_p is first high 1 cycle after req and then every cycle; 30 RAM writes; ram_wren never high before the first grant.
2. req_e=1, we_e=0, addr_e=5 with RAM row 5=40'h00_0000_00FF -> rvalid_e high 1 cycle after gnt_e, rdata=40'h00000000FF; rvalid_d stays 0.
3. req_p, req_e and req_d all raised together from IDLE -> preset owns until req_p drops; then the engine; the display is forced in no later than MAX_WAIT=16 cycles after req_d rose, for exactly 1 access.
4. Engine burst held for 100 cycles with req_d continuously high -> gnt_d pulses at least once every 17 cycles; each gnt_d is followed by rvalid_d; the engine resumes the next cycle.
5. Engine write to addr_e=30 (>= ROWS) -> gnt_e=1, ram_wren=0, err_oob=1 from the next cycle and stays 1; a read of addr 31 gives rvalid=1 with rdata=0.
6. reset_n asserted low mid-burst during a granted write -> gnt and ram_wren drop in the same cycle; owner=IDLE and err_oob=0 after release; the first grant comes 1 cycle after a new req.

Source files
------------

// File: rtl/board_ram_arbiter.sv
// Single-port board RAM arbiter: preset > engine > display with burst ownership,
// plus a starvation guard that forces the display in for one access.
module board_ram_arbiter #(
   parameter int WIDTH    = 40,
   parameter int AW       = 5,
   parameter int ROWS     = 30,
   parameter int MAX_WAIT = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_p,
   input  logic [AW-1:0]    addr_p,
   input  logic [WIDTH-1:0] wdata_p,
   output logic             gnt_p,
   input  logic             req_e,
   input  logic             we_e,
   input  logic [AW-1:0]    addr_e,
   input  logic [WIDTH-1:0] wdata_e,
   output logic             gnt_e,
   output logic             rvalid_e,
   input  logic             req_d,
   input  logic [AW-1:0]    addr_d,
   output logic             gnt_d,
   output logic             rvalid_d,
   output logic [WIDTH-1:0] rdata,
   output logic             err_oob,
   output logic [AW-1:0]    ram_addr,
   output logic [WIDTH-1:0] ram_data,
   output logic             ram_wren,
   input  logic [WIDTH-1:0] ram_q
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_MAX  = CW'(MAX_WAIT);
   localparam logic [CW-1:0] WAIT_FIRE = CW'(MAX_WAIT - 1);
   localparam logic [AW:0]   ROW_LIM   = (AW+1)'(ROWS);

   typedef enum logic [1:0] {IDLE, OWN_P, OWN_E, OWN_D} owner_t;

   owner_t           owner_q, owner_d;
   logic [CW-1:0]    wait_q, wait_d;
   logic             forced_q, forced_d;
   logic             rvalid_e_q, rvalid_d_q, rd_oob_q, err_q;
   logic [AW-1:0]    sel_addr;
   logic [WIDTH-1:0] sel_data;
   logic             sel_wr, any_gnt, oob, rd_e, fire;

   function automatic owner_t pick(input logic p, input logic e, input logic d);
      owner_t r;
      r = IDLE;
      if (p)      r = OWN_P;
      else if (e) r = OWN_E;
      else if (d) r = OWN_D;
      return r;
   endfunction

   // Grants and RAM drive follow the registered owner only
   always_comb begin
      gnt_p    = (owner_q == OWN_P) & req_p;
      gnt_e    = (owner_q == OWN_E) & req_e;
      gnt_d    = (owner_q == OWN_D) & req_d;
      sel_addr = '0;
      sel_data = '0;
      sel_wr   = 1'b0;
      if (gnt_p) begin
         sel_addr = addr_p;
         sel_data = wdata_p;
         sel_wr   = 1'b1;
      end else if (gnt_e) begin
         sel_addr = addr_e;
         sel_data = wdata_e;
         sel_wr   = we_e;
      end else if (gnt_d) begin
         sel_addr = addr_d;
      end
      any_gnt  = gnt_p | gnt_e | gnt_d;
      oob      = any_gnt & ({1'b0, sel_addr} >= ROW_LIM);
      rd_e     = gnt_e & ~we_e;
      ram_addr = sel_addr;
      ram_data = sel_data;
      ram_wren = sel_wr & ~oob;
   end

   // A forced display slot always re-arbitrates next, so the guard cannot chain
   always_comb begin
      owner_d  = owner_q;
      wait_d   = wait_q;
      forced_d = 1'b0;
      fire     = req_d & ~gnt_d & (wait_q >= WAIT_FIRE);
      if (gnt_d | ~req_d)
         wait_d = '0;
      else if (wait_q != WAIT_MAX)
         wait_d = wait_q + 1'b1;
      if (forced_q) begin
         owner_d = pick(req_p, req_e, req_d);
      end else if (fire) begin
         owner_d  = OWN_D;
         forced_d = 1'b1;
      end else begin
         case (owner_q)
            OWN_P:   if (!req_p) owner_d = pick(req_p, req_e, req_d);
            OWN_E:   if (!req_e) owner_d = pick(req_p, req_e, req_d);
            OWN_D:   if (!req_d) owner_d = pick(req_p, req_e, req_d);
            default: owner_d = pick(req_p, req_e, req_d);
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_q    <= IDLE;
         wait_q     <= '0;
         forced_q   <= 1'b0;
         rvalid_e_q <= 1'b0;
         rvalid_d_q <= 1'b0;
         rd_oob_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         owner_q    <= owner_d;
         wait_q     <= wait_d;
         forced_q   <= forced_d;
         rvalid_e_q <= rd_e;
         rvalid_d_q <= gnt_d;
         rd_oob_q   <= oob & (rd_e | gnt_d);
         err_q      <= err_q | oob;
      end
   end

   assign rvalid_e = rvalid_e_q;
   assign rvalid_d = rvalid_d_q;
   assign err_oob  = err_q;
   assign rdata    = rd_oob_q ? '0 : ram_q;
endmodule

// File: tb/tb_board_ram_arbiter.sv
// Bench for board_ram_arbiter: directed scenarios then constrained-random traffic,
// every cycle compared against an ownership/priority reference model.
module tb_board_ram_arbiter;
   localparam int WIDTH    = 40;
   localparam int AW       = 5;
   localparam int ROWS     = 30;
   localparam int MAX_WAIT = 16;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             req_p = 1'b0, req_e = 1'b0, we_e = 1'b0, req_d = 1'b0;
   logic [AW-1:0]    addr_p = '0, addr_e = '0, addr_d = '0;
   logic [WIDTH-1:0] wdata_p = '0, wdata_e = '0;
   logic             gnt_p, gnt_e, gnt_d, rvalid_e, rvalid_d, err_oob, ram_wren;
   logic [WIDTH-1:0] rdata, ram_data, ram_q;
   logic [AW-1:0]    ram_addr;

   int n_tests = 0;
   int n_fail  = 0;

   logic [WIDTH-1:0] mem     [32];
   logic [WIDTH-1:0] ref_mem [32];

   always #5 clk = ~clk;

   board_ram_arbiter #(.WIDTH(WIDTH), .AW(AW), .ROWS(ROWS), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_p(req_p), .addr_p(addr_p), .wdata_p(wdata_p), .gnt_p(gnt_p),
      .req_e(req_e), .we_e(we_e), .addr_e(addr_e), .wdata_e(wdata_e),
      .gnt_e(gnt_e), .rvalid_e(rvalid_e),
      .req_d(req_d), .addr_d(addr_d), .gnt_d(gnt_d), .rvalid_d(rvalid_d),
      .rdata(rdata), .err_oob(err_oob),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Board RAM: one-cycle synchronous read, old data on read-during-write
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      ram_q = '0;
      forever begin
         @(posedge clk);
         if (ram_wren) mem[ram_addr] <= ram_data;
         ram_q <= mem[ram_addr];
      end
   end

   // Reference model: owner 0=none 1=preset 2=engine 3=display
   int               m_owner, n_owner, m_wait, n_wait, waited;
   bit               m_forced, n_forced, m_rv_e, m_rv_d, n_rv_e, n_rv_d, m_err, n_err;
   logic [WIDTH-1:0] m_rdata, n_rdata, ed;
   logic [AW-1:0]    ea;
   bit               eg_p, eg_e, eg_d, bad, ew, owner_req;
   int               best;

   initial begin
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      m_owner = 0; m_wait = 0; m_forced = 0; m_rv_e = 0; m_rv_d = 0; m_rdata = '0; m_err = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            m_owner = 0; m_wait = 0; m_forced = 0; m_rv_e = 0; m_rv_d = 0; m_err = 0;
         end
         eg_p = (m_owner == 1) && req_p;
         eg_e = (m_owner == 2) && req_e;
         eg_d = (m_owner == 3) && req_d;
         ea   = eg_p ? addr_p : eg_e ? addr_e : eg_d ? addr_d : '0;
         ed   = eg_p ? wdata_p : eg_e ? wdata_e : '0;
         bad  = (eg_p || eg_e || eg_d) && (int'(ea) >= ROWS);
         ew   = (eg_p || (eg_e && we_e)) && !bad;
         chk("gnt", 64'({gnt_p, gnt_e, gnt_d}), 64'({eg_p, eg_e, eg_d}));
         chk("ram_wren", 64'(ram_wren), 64'(ew));
         chk("ram_addr", 64'(ram_addr), 64'(ea));
         chk("ram_data", 64'(ram_data), 64'(ed));
         chk("rvalid", 64'({rvalid_e, rvalid_d}), 64'({m_rv_e, m_rv_d}));
         if (m_rv_e || m_rv_d) chk("rdata", 64'(rdata), 64'(m_rdata));
         chk("err_oob", 64'(err_oob), 64'(m_err));

         n_rv_e  = eg_e && !we_e;
         n_rv_d  = eg_d;
         n_rdata = bad ? '0 : ref_mem[ea];
         n_err   = m_err || bad;
         waited  = (req_d && !eg_d) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
         n_wait  = waited;
         best    = req_p ? 1 : req_e ? 2 : req_d ? 3 : 0;
         owner_req = (m_owner == 1 && req_p) || (m_owner == 2 && req_e) || (m_owner == 3 && req_d);
         n_forced = 0;
         if (m_forced)                 n_owner = best;
         else if (waited >= MAX_WAIT) begin n_owner = 3; n_forced = 1; end
         else if (!owner_req)          n_owner = best;
         else                          n_owner = m_owner;

         @(posedge clk);
         if (reset_n) begin
            if (ew) ref_mem[ea] = ed;
            m_owner = n_owner; m_wait = n_wait; m_forced = n_forced;
            m_rv_e = n_rv_e; m_rv_d = n_rv_d; m_rdata = n_rdata; m_err = n_err;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic obs();
      @(negedge clk);
   endtask

   function automatic logic gsel(input int who);
      return (who == 1) ? gnt_p : (who == 2) ? gnt_e : gnt_d;
   endfunction

   task automatic await_gnt(input int who, input string tag);
      int n = 0;
      obs();
      while (gsel(who) == 1'b0 && n < 40) begin
         adv();
         obs();
         n++;
      end
      chk(tag, 64'(gsel(who)), 64'(1));
   endtask

   function automatic logic [AW-1:0] raddr();
      return ($urandom_range(0, 9) == 0) ? AW'($urandom_range(30, 31)) : AW'($urandom_range(0, 29));
   endfunction

   initial begin
      int ngr, nwr, d_idx, nd, last, maxgap, npair, nrv, nres;
      bit prev_d, lp, le, ld;
      logic [2:0] g [20];
      logic [2:0] after_d;

      repeat (3) adv();
      reset_n = 1'b1;

      // T1: preset fills rows 0..29
      adv();
      req_p = 1'b1; addr_p = '0; wdata_p = '0;
      obs();
      chk("t1_first_cycle_idle", 64'({gnt_p, ram_wren}), 64'(0));
      ngr = 0; nwr = 0;
      for (int i = 0; i < 30; i++) begin
         adv();
         addr_p = AW'(i); wdata_p = WIDTH'(i);
         obs();
         if (gnt_p) ngr++;
         if (ram_wren) nwr++;
      end
      chk("t1_grants", 64'(ngr), 64'(30));
      chk("t1_writes", 64'(nwr), 64'(30));

      // T2: engine writes FF to row 5 then reads it back
      adv();
      req_p = 1'b0; req_e = 1'b1; we_e = 1'b1; addr_e = 5; wdata_e = 40'h00_0000_00FF;
      await_gnt(2, "t2_write_gnt");
      adv();
      we_e = 1'b0;
      obs();
      chk("t2_read_gnt", 64'(gnt_e), 64'(1));
      adv();
      req_e = 1'b0;
      obs();
      chk("t2_rvalid", 64'({rvalid_e, rvalid_d}), 64'(2'b10));
      chk("t2_rdata", 64'(rdata), 64'h00_0000_00FF);

      // T3: all three requests from idle
      adv();
      req_p = 1'b1; addr_p = 3; wdata_p = WIDTH'({$urandom(), $urandom()});
      req_e = 1'b1; we_e = 1'b0; addr_e = 1; req_d = 1'b1; addr_d = 2;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) begin
            adv();
            req_p = (k < 9);
         end
         obs();
         g[k] = {gnt_p, gnt_e, gnt_d};
      end
      d_idx = -1; nd = 0;
      for (int k = 0; k < 20; k++) if (g[k] == 3'b001) begin
         nd++;
         if (d_idx < 0) d_idx = k;
      end
      after_d = (d_idx >= 0 && d_idx < 19) ? g[d_idx+1] : 3'b000;
      chk("t3_idle_first", 64'(g[0]), 64'(3'b000));
      chk("t3_preset_owns", 64'(g[1]), 64'(3'b100));
      chk("t3_preset_holds", 64'(g[8]), 64'(3'b100));
      chk("t3_engine_next", 64'(g[10]), 64'(3'b010));
      chk("t3_display_by_max_wait", 64'(d_idx >= 1 && d_idx <= MAX_WAIT), 64'(1));
      chk("t3_display_once", 64'(nd), 64'(1));
      chk("t3_engine_resumes", 64'(after_d), 64'(3'b010));

      // T4: long engine burst against a waiting display
      nd = 0; last = 0; maxgap = 0; npair = 0; nrv = 0; nres = 0; prev_d = 0;
      for (int j = 1; j <= 100; j++) begin
         adv();
         obs();
         if (prev_d) begin
            npair++;
            if (rvalid_d) nrv++;
            if (gnt_e) nres++;
         end
         prev_d = gnt_d;
         if (gnt_d) begin
            nd++;
            if (j - last > maxgap) maxgap = j - last;
            last = j;
         end
      end
      chk("t4_display_count", 64'(nd >= 5), 64'(1));
      chk("t4_max_gap", 64'(maxgap <= MAX_WAIT + 1), 64'(1));
      chk("t4_rvalid_d_follows", 64'(nrv), 64'(npair));
      chk("t4_engine_resume", 64'(nres), 64'(npair));
      adv();
      req_e = 1'b0; req_d = 1'b0;

      // T5: out-of-range write and read
      adv();
      req_e = 1'b1; we_e = 1'b1; addr_e = 30; wdata_e = WIDTH'({$urandom(), $urandom()});
      await_gnt(2, "t5_oob_write_gnt");
      chk("t5_no_wren", 64'(ram_wren), 64'(0));
      chk("t5_err_before", 64'(err_oob), 64'(0));
      adv();
      we_e = 1'b0; addr_e = 31;
      obs();
      chk("t5_read_gnt", 64'(gnt_e), 64'(1));
      chk("t5_err_set", 64'(err_oob), 64'(1));
      adv();
      req_e = 1'b0;
      obs();
      chk("t5_oob_rvalid", 64'(rvalid_e), 64'(1));
      chk("t5_oob_rdata", 64'(rdata), 64'(0));
      repeat (3) adv();
      obs();
      chk("t5_err_sticky", 64'(err_oob), 64'(1));

      // T6: reset in the middle of a granted write
      adv();
      req_p = 1'b1; addr_p = 7; wdata_p = WIDTH'({$urandom(), $urandom()});
      await_gnt(1, "t6_write_gnt");
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_gnt_drop", 64'(gnt_p), 64'(0));
      chk("t6_wren_drop", 64'(ram_wren), 64'(0));
      adv();
      req_p = 1'b0;
      adv();
      adv();
      reset_n = 1'b1;
      obs();
      chk("t6_err_cleared", 64'(err_oob), 64'(0));
      adv();
      req_p = 1'b1;
      obs();
      chk("t6_idle_after_reset", 64'(gnt_p), 64'(0));
      adv();
      obs();
      chk("t6_regrant", 64'(gnt_p), 64'(1));
      adv();
      req_p = 1'b0;

      // Random traffic; a requester waiting for a grant holds its request
      for (int c = 0; c < 1500; c++) begin
         obs();
         lp = gnt_p; le = gnt_e; ld = gnt_d;
         adv();
         if (!(req_p && !lp)) begin
            req_p = ($urandom_range(0, 3) == 0);
            addr_p = raddr();
            wdata_p = WIDTH'({$urandom(), $urandom()});
         end
         if (!(req_e && !le)) begin
            req_e = ($urandom_range(0, 1) == 0);
            we_e = $urandom_range(0, 1) == 1;
            addr_e = raddr();
            wdata_e = WIDTH'({$urandom(), $urandom()});
         end
         if (!(req_d && !ld)) begin
            req_d = ($urandom_range(0, 1) == 0);
            addr_d = raddr();
         end
      end
      adv();
      req_p = 1'b0; req_e = 1'b0; req_d = 1'b0;
      repeat (3) adv();
      obs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
